// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings and helpers for the branch prediction unit.
// The PC-select encoding matches what the IF-stage PC mux decodes.
package branch_predict_unit_pkg;

    localparam int unsigned PC_WIDTH_DEF    = 32;
    localparam int unsigned BTB_ENTRIES_DEF = 16;

    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'd0,
        PC_SEL_BTB    = 2'd1,
        PC_SEL_EX_SEQ = 2'd2,
        PC_SEL_EX_TGT = 2'd3
    } pc_sel_e;

    localparam logic [1:0] CNT_WEAK_T = 2'b10;

    function automatic logic [1:0] cnt_sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predict_unit_btb_array.sv
// Direct-mapped BTB storage: combinational read on the fetch PC, clocked
// write/update on the resolving PC. Only valid bits and counters are reset.
module branch_predict_unit_btb_array
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEF,
    parameter int unsigned ENTRIES  = BTB_ENTRIES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] rd_pc_i,
    output logic                rd_hit_o,
    output logic                rd_taken_o,
    output logic [PC_WIDTH-1:0] rd_target_o,
    input  logic                wr_en_i,
    input  logic [PC_WIDTH-1:0] wr_pc_i,
    input  logic                wr_taken_i,
    input  logic [PC_WIDTH-1:0] wr_target_i
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_WIDTH - IDX_W - 2;

    logic [ENTRIES-1:0]  valid_q;
    logic [1:0]          cnt_q [ENTRIES];
    logic [TAG_W-1:0]    tag_q [ENTRIES];
    logic [PC_WIDTH-1:0] tgt_q [ENTRIES];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             wr_hit;
    logic             unused_pc_lsbs;

    assign rd_idx = rd_pc_i[IDX_W+1:2];
    assign rd_tag = rd_pc_i[PC_WIDTH-1:IDX_W+2];
    assign wr_idx = wr_pc_i[IDX_W+1:2];
    assign wr_tag = wr_pc_i[PC_WIDTH-1:IDX_W+2];
    assign unused_pc_lsbs = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

    assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_taken_o  = rd_hit_o && cnt_q[rd_idx][1];
    assign rd_target_o = rd_hit_o ? tgt_q[rd_idx] : '0;

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            if (wr_hit) begin
                cnt_q[wr_idx] <= cnt_sat_update(cnt_q[wr_idx], wr_taken_i);
            end else if (wr_taken_i) begin
                valid_q[wr_idx] <= 1'b1;
                cnt_q[wr_idx]   <= CNT_WEAK_T;
            end
        end
    end

    // On a hit the stored tag already equals wr_tag, so any taken resolve may rewrite both.
    always_ff @(posedge clk) begin
        if (wr_en_i && wr_taken_i) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= wr_target_i;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: BTB lookup for IF, branch resolution from EX,
// PC-select/flush generation and a saturating mispredict counter.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = PC_WIDTH_DEF,
    parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] IF_PC,
    input  logic                EX_valid,
    input  logic                EX_is_ctrl,
    input  logic                EX_taken,
    input  logic [PC_WIDTH-1:0] EX_PC,
    input  logic [PC_WIDTH-1:0] EX_ALU_Result,
    input  logic                EX_pred_taken,
    input  logic [PC_WIDTH-1:0] EX_pred_target,
    output logic [1:0]          PC_sel,
    output logic [PC_WIDTH-1:0] BTB_PC,
    output logic                IF_pred_taken,
    output logic                flush,
    output logic [CNT_W-1:0]    mispredict_count
);

    logic       resolve;
    logic       mis_tgt, mis_nt;
    logic       if_hit;
    pc_sel_e    sel;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    branch_predict_unit_btb_array #(
        .PC_WIDTH (PC_WIDTH),
        .ENTRIES  (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .rd_pc_i     (IF_PC),
        .rd_hit_o    (if_hit),
        .rd_taken_o  (IF_pred_taken),
        .rd_target_o (BTB_PC),
        .wr_en_i     (resolve),
        .wr_pc_i     (EX_PC),
        .wr_taken_i  (EX_taken),
        .wr_target_i (EX_ALU_Result)
    );

    assign resolve = EX_valid && EX_is_ctrl;
    assign mis_tgt = resolve && EX_taken &&
                     (!EX_pred_taken || (EX_pred_target != EX_ALU_Result));
    assign mis_nt  = resolve && !EX_taken && EX_pred_taken;
    assign flush   = mis_tgt || mis_nt;

    always_comb begin
        sel = PC_SEL_SEQ;
        if (mis_tgt) begin
            sel = PC_SEL_EX_TGT;
        end else if (mis_nt) begin
            sel = PC_SEL_EX_SEQ;
        end else if (IF_pred_taken) begin
            sel = PC_SEL_BTB;
        end
    end

    assign PC_sel = sel;

    always_comb begin
        mcnt_d = mcnt_q;
        if (flush && (mcnt_q != '1)) begin
            mcnt_d = mcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt_q <= '0;
        end else begin
            mcnt_q <= mcnt_d;
        end
    end

    assign mispredict_count = mcnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios with literal
// expectations plus randomized traffic against a behavioural BTB model.
module tb_branch_predict_unit;

    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IF_PC;
    logic        EX_valid, EX_is_ctrl, EX_taken, EX_pred_taken;
    logic [31:0] EX_PC, EX_ALU_Result, EX_pred_target;
    logic [1:0]  PC_sel;
    logic [31:0] BTB_PC;
    logic        IF_pred_taken, flush;
    logic [CW-1:0] mispredict_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Behavioural model: per-index owner key (PC >> 6), target, and 0..3 confidence.
    bit          m_valid [16];
    int unsigned m_key   [16];
    int unsigned m_tgt   [16];
    int unsigned m_conf  [16];
    int unsigned m_count;

    int unsigned pool [8] = '{32'h100, 32'h140, 32'h104, 32'h200, 32'h1100, 32'h3c, 32'h280, 32'h102};

    branch_predict_unit #(
        .PC_WIDTH    (32),
        .BTB_ENTRIES (16),
        .CNT_W       (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .IF_PC            (IF_PC),
        .EX_valid         (EX_valid),
        .EX_is_ctrl       (EX_is_ctrl),
        .EX_taken         (EX_taken),
        .EX_PC            (EX_PC),
        .EX_ALU_Result    (EX_ALU_Result),
        .EX_pred_taken    (EX_pred_taken),
        .EX_pred_target   (EX_pred_target),
        .PC_sel           (PC_sel),
        .BTB_PC           (BTB_PC),
        .IF_pred_taken    (IF_pred_taken),
        .flush            (flush),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int unsigned idx_of(input int unsigned pc);
        return (pc / 4) % 16;
    endfunction

    function automatic bit m_hit(input int unsigned pc);
        return m_valid[idx_of(pc)] && (m_key[idx_of(pc)] == pc / 64);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_conf[i]  = 0;
        end
        m_count = 0;
    endtask

    task automatic expect_mis(output bit mt, output bit mn);
        bit res;
        res = EX_valid && EX_is_ctrl;
        mt  = res && EX_taken && (!EX_pred_taken || EX_pred_target != EX_ALU_Result);
        mn  = res && !EX_taken && EX_pred_taken;
    endtask

    task automatic check_now();
        bit          hit, pt, mt, mn;
        int unsigned esel, ebtb;
        hit  = m_hit(IF_PC);
        pt   = hit && (m_conf[idx_of(IF_PC)] >= 2);
        ebtb = hit ? m_tgt[idx_of(IF_PC)] : 0;
        expect_mis(mt, mn);
        esel = mt ? 3 : (mn ? 2 : (pt ? 1 : 0));
        chk("PC_sel", {30'd0, PC_sel}, esel);
        chk("BTB_PC", BTB_PC, ebtb);
        chk("IF_pred_taken", {31'd0, IF_pred_taken}, {31'd0, pt});
        chk("flush", {31'd0, flush}, {31'd0, mt | mn});
        chk("mispredict_count", {28'd0, mispredict_count}, m_count);
    endtask

    task automatic model_step();
        bit          mt, mn;
        int unsigned i;
        if (rst) return;
        expect_mis(mt, mn);
        if ((mt || mn) && m_count < CMAX) m_count++;
        if (!(EX_valid && EX_is_ctrl)) return;
        i = idx_of(EX_PC);
        if (m_hit(EX_PC)) begin
            if (EX_taken) begin
                if (m_conf[i] < 3) m_conf[i]++;
                m_tgt[i] = EX_ALU_Result;
            end else if (m_conf[i] > 0) begin
                m_conf[i]--;
            end
        end else if (EX_taken) begin
            m_valid[i] = 1;
            m_key[i]   = EX_PC / 64;
            m_tgt[i]   = EX_ALU_Result;
            m_conf[i]  = 2;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_now();
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input bit v, input bit c, input bit t, input int unsigned pc,
                          input int unsigned alu, input bit pt, input int unsigned ptgt);
        EX_valid = v; EX_is_ctrl = c; EX_taken = t; EX_PC = pc;
        EX_ALU_Result = alu; EX_pred_taken = pt; EX_pred_target = ptgt;
    endtask

    initial begin
        rst = 1'b1;
        IF_PC = 32'h100;
        set_ex(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset state
        sample();
        chk("t1_sel", {30'd0, PC_sel}, 0);
        chk("t1_btb", BTB_PC, 0);
        chk("t1_cnt", {28'd0, mispredict_count}, 0);
        adv();

        // 2: taken branch allocates
        set_ex(1, 1, 1, 32'h100, 32'h200, 0, 0);
        sample();
        chk("t2_sel", {30'd0, PC_sel}, 3);
        chk("t2_flush", {31'd0, flush}, 1);
        adv();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("t2_hit_sel", {30'd0, PC_sel}, 1);
        chk("t2_hit_btb", BTB_PC, 32'h200);
        adv();

        // 3: not-taken mispredict weakens the entry
        set_ex(1, 1, 0, 32'h100, 32'h104, 1, 32'h200);
        sample();
        chk("t3_sel", {30'd0, PC_sel}, 2);
        chk("t3_flush", {31'd0, flush}, 1);
        adv();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("t3_pred", {31'd0, IF_pred_taken}, 0);
        chk("t3_sel2", {30'd0, PC_sel}, 0);
        adv();

        // 4: alias overwrites index 0
        set_ex(1, 1, 1, 32'h140, 32'h300, 0, 0);
        sample();
        adv();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("t4_miss_btb", BTB_PC, 0);
        IF_PC = 32'h140;
        #1 check_now();
        chk("t4_hit_btb", BTB_PC, 32'h300);
        chk("t4_cnt", {28'd0, mispredict_count}, 3);
        adv();

        // 5: JALR wrong target
        set_ex(1, 1, 1, 32'h140, 32'h280, 1, 32'h200);
        sample();
        chk("t5_sel", {30'd0, PC_sel}, 3);
        adv();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("t5_btb", BTB_PC, 32'h280);
        adv();

        // 6: EX mispredict overrides IF hit, then async reset mid-flush
        set_ex(1, 1, 1, 32'h500, 32'h600, 0, 0);
        sample();
        chk("t6_sel", {30'd0, PC_sel}, 3);
        rst = 1'b1;
        #1;
        model_reset();
        check_now();
        chk("t6_rst_btb", BTB_PC, 0);
        chk("t6_rst_cnt", {28'd0, mispredict_count}, 0);
        chk("t6_rst_sel", {30'd0, PC_sel}, 3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_ex(1, 1, 1, 32'h140, 32'h280, 1, 32'h280);
            sample();
            adv();
        end
        set_ex(1, 1, 0, 32'h140, 32'h144, 0, 0);
        sample();
        adv();
        sample();
        chk("t6_sat_pred", {31'd0, IF_pred_taken}, 1);
        adv();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("t6_weak_pred", {31'd0, IF_pred_taken}, 0);
        adv();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            IF_PC = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 7)];
            set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
                   $urandom_range(0, 1) == 1, 0);
            EX_pred_target = ($urandom_range(0, 1) == 1) ? EX_ALU_Result : pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
            end
            sample();
            adv();
            rst = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
